// File: rtl/ysyx_23060187_wbu.sv
// Write-back stage: one instruction in flight, optional store over a write-only AXI-lite channel, then RF write + commit pulse.
// Optional store-response watchdog is enabled by defining YSYX_23060187_WBU_TIMEOUT_EN.
module ysyx_23060187_wbu #(
  parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exu_valid,
  output logic        wbu_ready,
  input  logic        reg_wen,
  input  logic [31:0] reg_waddr,
  input  logic [31:0] reg_wdata,
  input  logic        mem_wen,
  input  logic [31:0] mem_waddr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        aw_valid,
  input  logic        aw_ready,
  output logic [31:0] aw_addr,
  output logic [31:0] w_data,
  output logic [3:0]  w_strb,
  input  logic        b_valid,
  input  logic [1:0]  b_resp,
  output logic        b_ready,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        commit_valid,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_RESP = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic        reg_wen_r;
  logic [4:0]  reg_waddr_r;
  logic [31:0] reg_wdata_r;
  logic [31:0] mem_waddr_r;
  logic [31:0] mem_wdata_r;
  logic [3:0]  mem_wstrb_r;
  logic        err_r;
  logic        err_set_s;
  logic        to_set_s;
  logic        to_r;
  logic        accept_s;

  assign accept_s = (state_r == IDLE) && exu_valid;

`ifdef YSYX_23060187_WBU_TIMEOUT_EN
  logic [7:0] cnt_r;

  // Watchdog counter and "this instruction timed out" flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 8'd0;
      to_r  <= 1'b0;
    end else begin
      if ((state_r == MEM_REQ) || (state_r == MEM_RESP)) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= 8'd0;
      end
      if (accept_s) begin
        to_r <= 1'b0;
      end else if (to_set_s) begin
        to_r <= 1'b1;
      end else begin
        to_r <= to_r;
      end
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{TIMEOUT_CYC, to_set_s};
  assign to_r = 1'b0;
`endif

  logic unused_addr_s;
  assign unused_addr_s = ^reg_waddr[31:5];

  // State register, captured instruction and sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      reg_wen_r   <= 1'b0;
      reg_waddr_r <= 5'd0;
      reg_wdata_r <= 32'd0;
      mem_waddr_r <= 32'd0;
      mem_wdata_r <= 32'd0;
      mem_wstrb_r <= 4'd0;
      err_r       <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        reg_wen_r   <= reg_wen;
        reg_waddr_r <= reg_waddr[4:0];
        reg_wdata_r <= reg_wdata;
        mem_waddr_r <= mem_waddr;
        mem_wdata_r <= mem_wdata;
        mem_wstrb_r <= mem_wstrb;
      end else begin
        reg_wen_r   <= reg_wen_r;
        reg_waddr_r <= reg_waddr_r;
        reg_wdata_r <= reg_wdata_r;
        mem_waddr_r <= mem_waddr_r;
        mem_wdata_r <= mem_wdata_r;
        mem_wstrb_r <= mem_wstrb_r;
      end
      if (err_set_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  // Next-state and output decode from the state register
  always_comb begin
    state_s      = state_r;
    aw_valid     = 1'b0;
    b_ready      = 1'b0;
    rf_wen       = 1'b0;
    commit_valid = 1'b0;
    err_set_s    = 1'b0;
    to_set_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (exu_valid) begin
          state_s = mem_wen ? MEM_REQ : COMMIT;
        end else begin
          state_s = IDLE;
        end
      end
      MEM_REQ: begin
        aw_valid = 1'b1;
        if (aw_ready) begin
          state_s = MEM_RESP;
        end else begin
          state_s = MEM_REQ;
        end
      end
      MEM_RESP: begin
        b_ready = 1'b1;
        if (b_valid) begin
          state_s   = COMMIT;
          err_set_s = (b_resp != 2'b00);
        end else begin
          state_s = MEM_RESP;
        end
      end
      COMMIT: begin
        commit_valid = 1'b1;
        rf_wen       = reg_wen_r && (reg_waddr_r != 5'd0) && !to_r;
        state_s      = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
`ifdef YSYX_23060187_WBU_TIMEOUT_EN
    // Watchdog expiry abandons the store and retires without an RF write
    if (((state_r == MEM_REQ) || (state_r == MEM_RESP)) && (cnt_r == TIMEOUT_CYC)) begin
      state_s   = COMMIT;
      aw_valid  = 1'b0;
      b_ready   = 1'b0;
      err_set_s = 1'b1;
      to_set_s  = 1'b1;
    end else begin
      to_set_s  = 1'b0;
    end
`endif
  end

  assign wbu_ready = (state_r == IDLE);
  assign aw_addr   = mem_waddr_r;
  assign w_data    = mem_wdata_r;
  assign w_strb    = mem_wstrb_r;
  assign rf_waddr  = reg_waddr_r;
  assign rf_wdata  = reg_wdata_r;
  assign err       = err_r;

endmodule

// File: tb/tb_ysyx_23060187_wbu.sv
// Directed self-checking bench for ysyx_23060187_wbu (default build, watchdog disabled).
module tb_ysyx_23060187_wbu;
  logic        clk = 1'b0;
  logic        rst;
  logic        exu_valid, wbu_ready, reg_wen, mem_wen;
  logic [31:0] reg_waddr, reg_wdata, mem_waddr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        aw_valid, aw_ready, b_valid, b_ready;
  logic [31:0] aw_addr, w_data;
  logic [3:0]  w_strb;
  logic [1:0]  b_resp;
  logic        rf_wen, commit_valid, err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  int checks = 0;
  int failures = 0;

  ysyx_23060187_wbu dut (
    .clk(clk), .rst(rst), .exu_valid(exu_valid), .wbu_ready(wbu_ready),
    .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit_valid(commit_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({wbu_ready, aw_valid, b_ready, rf_wen, commit_valid, err} !== 6'b100000) begin
      failures++;
      $display("FAIL %s_ctrl got=%b exp=100000", tag, {wbu_ready, aw_valid, b_ready, rf_wen, commit_valid, err});
    end
    checks++;
    if ({aw_addr, w_data, w_strb, rf_waddr, rf_wdata} !== 105'd0) begin
      failures++;
      $display("FAIL %s_data got=%h/%h/%h/%h/%h exp=0", tag, aw_addr, w_data, w_strb, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; exu_valid = 1'b0; reg_wen = 1'b0; reg_waddr = 32'd0; reg_wdata = 32'd0;
    mem_wen = 1'b0; mem_waddr = 32'd0; mem_wdata = 32'd0; mem_wstrb = 4'd0;
    aw_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset_idle");
  endtask

  // Issue a non-store instruction and check the commit cycle and the cycle after
  task automatic test_alu(input logic [31:0] addr, input logic [31:0] data, input logic exp_wen, input string tag);
    exu_valid = 1'b1; reg_wen = 1'b1; reg_waddr = addr; reg_wdata = data; mem_wen = 1'b0;
    @(negedge clk);
    exu_valid = 1'b0; reg_wdata = 32'h0;
    checks++;
    if ({commit_valid, rf_wen, wbu_ready, aw_valid} !== {1'b1, exp_wen, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL %s_commit got=%b exp=%b", tag, {commit_valid, rf_wen, wbu_ready, aw_valid}, {1'b1, exp_wen, 2'b00});
    end
    checks++;
    if ({rf_waddr, rf_wdata} !== {addr[4:0], data}) begin
      failures++;
      $display("FAIL %s_rfdata got=%h/%h exp=%h/%h", tag, rf_waddr, rf_wdata, addr[4:0], data);
    end
    @(negedge clk);
    checks++;
    if ({commit_valid, rf_wen, wbu_ready} !== 3'b001) begin
      failures++;
      $display("FAIL %s_after got=%b exp=001", tag, {commit_valid, rf_wen, wbu_ready});
    end
  endtask

  task automatic test_store_backpressure();
    exu_valid = 1'b1; reg_wen = 1'b1; reg_waddr = 32'd7; reg_wdata = 32'hCAFE0007;
    mem_wen = 1'b1; mem_waddr = 32'h8000_0010; mem_wdata = 32'h12345678; mem_wstrb = 4'b0011;
    aw_ready = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      // garbage on the inputs must not disturb the held payload
      exu_valid = 1'b1; mem_waddr = 32'hFFFF_0000 + i; mem_wdata = 32'h0; mem_wstrb = 4'b1100;
      checks++;
      if ({aw_valid, b_ready, commit_valid, wbu_ready} !== 4'b1000) begin
        failures++;
        $display("FAIL st_req%0d got=%b exp=1000", i, {aw_valid, b_ready, commit_valid, wbu_ready});
      end
      checks++;
      if ({aw_addr, w_data, w_strb} !== {32'h8000_0010, 32'h12345678, 4'b0011}) begin
        failures++;
        $display("FAIL st_payload%0d got=%h/%h/%b exp=80000010/12345678/0011", i, aw_addr, w_data, w_strb);
      end
      aw_ready = (i == 3);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      exu_valid = 1'b0; aw_ready = 1'b0;
      checks++;
      if ({aw_valid, b_ready, commit_valid, wbu_ready} !== 4'b0100) begin
        failures++;
        $display("FAIL st_resp%0d got=%b exp=0100", j, {aw_valid, b_ready, commit_valid, wbu_ready});
      end
      b_valid = (j == 2); b_resp = 2'b00;
    end
    @(negedge clk);
    b_valid = 1'b0; mem_wen = 1'b0;
    checks++;
    if ({commit_valid, rf_wen, rf_waddr, rf_wdata, err, wbu_ready, b_ready} !== {1'b1, 1'b1, 5'd7, 32'hCAFE0007, 3'b000}) begin
      failures++;
      $display("FAIL st_commit got=%b/%b/%h/%h/%b%b%b exp=1/1/07/cafe0007/000", commit_valid, rf_wen, rf_waddr, rf_wdata, err, wbu_ready, b_ready);
    end
    @(negedge clk);
    checks++;
    if ({commit_valid, wbu_ready} !== 2'b01) begin
      failures++;
      $display("FAIL st_after got=%b exp=01", {commit_valid, wbu_ready});
    end
  endtask

  task automatic test_err_resp();
    exu_valid = 1'b1; reg_wen = 1'b0; reg_waddr = 32'd3; mem_wen = 1'b1;
    mem_waddr = 32'h0000_0100; mem_wdata = 32'hA5A5A5A5; mem_wstrb = 4'b1111;
    aw_ready = 1'b1; b_valid = 1'b1; b_resp = 2'b10;
    @(negedge clk);
    exu_valid = 1'b0; mem_wen = 1'b0;
    checks++;
    if ({aw_valid, b_ready, err} !== 3'b100) begin
      failures++;
      $display("FAIL err_req got=%b exp=100", {aw_valid, b_ready, err});
    end
    @(negedge clk);
    checks++;
    if ({aw_valid, b_ready, err} !== 3'b010) begin
      failures++;
      $display("FAIL err_resp got=%b exp=010", {aw_valid, b_ready, err});
    end
    @(negedge clk);
    aw_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    checks++;
    if ({commit_valid, rf_wen, err} !== 3'b101) begin
      failures++;
      $display("FAIL err_commit got=%b exp=101", {commit_valid, rf_wen, err});
    end
    @(negedge clk);
    test_alu(32'd9, 32'h0000_0009, 1'b1, "err_clean");
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got=%b exp=1", err);
    end
  endtask

  task automatic test_reset_mid();
    exu_valid = 1'b1; reg_wen = 1'b1; reg_waddr = 32'd4; reg_wdata = 32'h4444_4444;
    mem_wen = 1'b1; mem_waddr = 32'h2000_0000; mem_wdata = 32'h5555_5555; mem_wstrb = 4'b0001;
    aw_ready = 1'b1; b_valid = 1'b0;
    @(negedge clk);
    exu_valid = 1'b0; mem_wen = 1'b0;
    @(negedge clk);
    aw_ready = 1'b0;
    checks++;
    if (b_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_inresp got=%b exp=1", b_ready);
    end
    rst = 1'b0;
    #1;
    check_reset_outputs("rstmid_async");
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({commit_valid, wbu_ready, aw_valid, b_ready} !== 4'b0100) begin
        failures++;
        $display("FAIL rstmid_quiet%0d got=%b exp=0100", k, {commit_valid, wbu_ready, aw_valid, b_ready});
      end
    end
    test_alu(32'd31, 32'h1357_9BDF, 1'b1, "rstmid_next");
  endtask

  initial begin
    test_reset();
    test_alu(32'd5, 32'hDEADBEEF, 1'b1, "alu");
    test_alu(32'd0, 32'h1111_2222, 1'b0, "x0");
    test_alu(32'hFFFF_FFE3, 32'h0BAD_F00D, 1'b1, "hiaddr");
    test_store_backpressure();
    test_err_resp();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog bench did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
